// File: rtl/ir_encoder.sv
// NEC-format infrared transmitter.
// Serialises a 32-bit command LSB-first as leader, 32 pulse-distance bits and
// a stop mark. ir_envelope is the unmodulated mark/space waveform and
// ir_output is the envelope gated by the carrier. Both outputs are registered
// from next-state values, so they line up with the state they describe.
module ir_encoder #(
  parameter int TICK_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [31:0] command,
  output logic        busy,
  output logic        done,
  output logic        ir_envelope,
  output logic        ir_output
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HIGH  = CW'(CARRIER_HIGH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] tick_cnt_r, tick_cnt_nxt_s;
  logic [4:0]    phase_cnt_r, phase_cnt_nxt_s;
  logic [4:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [31:0]   shift_r, shift_nxt_s;
  logic [CW-1:0] car_cnt_r, car_cnt_nxt_s;
  logic          busy_r, done_r, env_r, out_r;
  logic          busy_nxt_s, done_nxt_s, env_nxt_s, out_nxt_s;
  logic          accept_s, tick_s, phase_end_s, more_bits_s;
  logic [4:0]    phase_len_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign ir_envelope = env_r;
  assign ir_output   = out_r;

  // Phase timing: unit tick, length of the current phase and its end condition
  always_comb begin
    accept_s    = (state_r == IDLE) && start;
    tick_s      = (tick_cnt_r == TICK_LAST);
    more_bits_s = (bit_cnt_r < 5'd31);
    case (state_r)
      LEAD_MARK:  phase_len_s = 5'd16;
      LEAD_SPACE: phase_len_s = 5'd8;
      BIT_MARK:   phase_len_s = 5'd1;
      BIT_SPACE:  phase_len_s = shift_r[0] ? 5'd3 : 5'd1;
      STOP_MARK:  phase_len_s = 5'd1;
      default:    phase_len_s = 5'd1;
    endcase
    phase_end_s = tick_s && (phase_cnt_r == (phase_len_s - 5'd1));
  end

  // State register; holds while enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (enable) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: each phase advances once it has run its length
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LEAD_MARK;
        else       state_nxt_s = IDLE;
      end
      LEAD_MARK: begin
        if (phase_end_s) state_nxt_s = LEAD_SPACE;
        else             state_nxt_s = LEAD_MARK;
      end
      LEAD_SPACE: begin
        if (phase_end_s) state_nxt_s = BIT_MARK;
        else             state_nxt_s = LEAD_SPACE;
      end
      BIT_MARK: begin
        if (phase_end_s) state_nxt_s = BIT_SPACE;
        else             state_nxt_s = BIT_MARK;
      end
      BIT_SPACE: begin
        if (phase_end_s) state_nxt_s = more_bits_s ? BIT_MARK : STOP_MARK;
        else             state_nxt_s = BIT_SPACE;
      end
      STOP_MARK: begin
        if (phase_end_s) state_nxt_s = IDLE;
        else             state_nxt_s = STOP_MARK;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: unit timer, phase counter, bit shifter, carrier phase
  always_comb begin
    if (accept_s || (state_r == IDLE)) begin
      tick_cnt_nxt_s  = {TW{1'b0}};
      phase_cnt_nxt_s = 5'd0;
    end else begin
      tick_cnt_nxt_s  = tick_s ? {TW{1'b0}} : (tick_cnt_r + {{(TW-1){1'b0}}, 1'b1});
      if (phase_end_s)  phase_cnt_nxt_s = 5'd0;
      else if (tick_s)  phase_cnt_nxt_s = phase_cnt_r + 5'd1;
      else              phase_cnt_nxt_s = phase_cnt_r;
    end

    if (accept_s) begin
      shift_nxt_s   = command;
      bit_cnt_nxt_s = 5'd0;
    end else if ((state_r == BIT_SPACE) && phase_end_s && more_bits_s) begin
      shift_nxt_s   = shift_r >> 1;
      bit_cnt_nxt_s = bit_cnt_r + 5'd1;
    end else begin
      shift_nxt_s   = shift_r;
      bit_cnt_nxt_s = bit_cnt_r;
    end

    // Clearing on acceptance keeps every frame starting in carrier phase
    if (accept_s || (state_r == IDLE)) begin
      car_cnt_nxt_s = {CW{1'b0}};
    end else begin
      car_cnt_nxt_s = (car_cnt_r == CAR_LAST) ? {CW{1'b0}} : (car_cnt_r + {{(CW-1){1'b0}}, 1'b1});
    end
  end

  // Output logic, computed from next-state values so the registers align
  always_comb begin
    case (state_nxt_s)
      LEAD_MARK, BIT_MARK, STOP_MARK: env_nxt_s = 1'b1;
      default:                        env_nxt_s = 1'b0;
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r == STOP_MARK) && (state_nxt_s == IDLE);
    out_nxt_s  = env_nxt_s && (car_cnt_nxt_s < CAR_HIGH);
  end

  // Datapath and output registers; all hold while enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r  <= {TW{1'b0}};
      phase_cnt_r <= 5'd0;
      bit_cnt_r   <= 5'd0;
      shift_r     <= 32'd0;
      car_cnt_r   <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      env_r       <= 1'b0;
      out_r       <= 1'b0;
    end else if (enable) begin
      tick_cnt_r  <= tick_cnt_nxt_s;
      phase_cnt_r <= phase_cnt_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      car_cnt_r   <= car_cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      env_r       <= env_nxt_s;
      out_r       <= out_nxt_s;
    end
  end

endmodule

// File: tb/tb_ir_encoder.sv
// Directed bench for ir_encoder with a scoreboard of expected frames.
module tb_ir_encoder;

  localparam int T   = 4;
  localparam int DIV = 3;
  localparam int HI  = 1;

  logic        clk = 1'b0;
  logic        rst, enable, start;
  logic [31:0] command;
  logic        busy, done, ir_envelope, ir_output;

  typedef struct {
    logic [31:0] cmd;
    int          len;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ir_encoder #(.TICK_CYCLES(T), .CARRIER_DIV(DIV), .CARRIER_HIGH(HI)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .command(command),
    .busy(busy), .done(done), .ir_envelope(ir_envelope), .ir_output(ir_output)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcnt(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // Drive a one-cycle start; leaves time at the negedge of the first busy cycle
  task automatic send(input logic [31:0] cmd, input bit immediate);
    exp_t e;
    if (!immediate) @(negedge clk);
    command = cmd;
    start   = 1'b1;
    e.cmd   = cmd;
    e.len   = (89 + 2 * popcnt(cmd)) * T;
    sb_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    command = $urandom;
  endtask

  // Follow one frame from its first busy cycle to the done cycle
  task automatic capture(input string tag, input int fz_at, input int fz_len,
                         input int st1, input int st2);
    exp_t e;
    bit   exp_env[$];
    bit   env_q[$];
    int   runs[$];
    int   total = 0, k = 0, hold_err = 0, done_in = 0, env_err = 0, out_err = 0;
    int   run_len;
    bit   timeout = 1'b0, cur, eo;
    logic [31:0] dec;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 16 * T; i++) exp_env.push_back(1'b1);
    for (int i = 0; i < 8 * T; i++)  exp_env.push_back(1'b0);
    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < T; i++) exp_env.push_back(1'b1);
      for (int i = 0; i < (e.cmd[b] ? 3 * T : T); i++) exp_env.push_back(1'b0);
    end
    for (int i = 0; i < T; i++) exp_env.push_back(1'b1);

    while (busy === 1'b1) begin
      env_q.push_back(ir_envelope);
      if (k < exp_env.size()) begin
        eo = exp_env[k] && ((k % DIV) < HI);
        if (ir_envelope !== exp_env[k]) env_err++;
        if (ir_output !== eo) out_err++;
      end else begin
        env_err++;
        eo = 1'b0;
      end
      if (done !== 1'b0) done_in++;
      if (k == fz_at) begin
        enable = 1'b0;
        repeat (fz_len) begin
          @(negedge clk);
          total++;
          if ({busy, done, ir_envelope, ir_output} !== {1'b1, 1'b0, exp_env[k], eo}) hold_err++;
        end
        enable = 1'b1;
      end
      start = (k == st1) || (k == st2);
      @(negedge clk);
      k++;
      total++;
      if (total > 5000) begin
        timeout = 1'b1;
        break;
      end
    end
    start = 1'b0;

    check({tag, " timeout"}, 64'(timeout), 64'd0);
    check({tag, " busy length"}, 64'(total), 64'(e.len + fz_len));
    check({tag, " envelope errors"}, 64'(env_err), 64'd0);
    check({tag, " ir_output errors"}, 64'(out_err), 64'd0);
    check({tag, " done while busy"}, 64'(done_in), 64'd0);
    check({tag, " end done/env/out"}, {61'd0, done, ir_envelope, ir_output}, 64'b100);
    if (fz_len > 0) check({tag, " freeze hold errors"}, 64'(hold_err), 64'd0);

    // Loopback decode of the observed envelope by mark/space run lengths
    cur     = 1'b1;
    run_len = 0;
    foreach (env_q[i]) begin
      if (env_q[i] == cur) run_len++;
      else begin
        runs.push_back(run_len);
        cur     = env_q[i];
        run_len = 1;
      end
    end
    runs.push_back(run_len);
    dec = 32'd0;
    if (runs.size() == 67) begin
      for (int b = 0; b < 32; b++) dec[b] = (runs[3 + 2 * b] > 2 * T);
    end
    check({tag, " decoded command"}, 64'(dec), 64'(e.cmd));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    start   = 1'b0;
    command = 32'd0;
    #1;
    check("reset outputs", {60'd0, busy, done, ir_envelope, ir_output}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {60'd0, busy, done, ir_envelope, ir_output}, 64'd0);

    send(32'h00FF00FF, 1'b0);
    capture("f1", -1, 0, -1, -1);
    @(negedge clk);
    check("f1 done one cycle", {62'd0, busy, done}, 64'd0);

    send(32'h00000000, 1'b0);
    capture("f2", -1, 0, -1, -1);

    send(32'hA55A1234, 1'b0);
    capture("f3", -1, 0, -1, -1);

    send(32'h12345678, 1'b0);
    capture("f4", -1, 0, 10, 200);
    send(32'h0F0F0F0F, 1'b1);
    check("f5 restart on done", {62'd0, busy, done}, 64'b10);
    capture("f5", -1, 0, -1, -1);

    send(32'hDEADBEEF, 1'b0);
    capture("f6", 16 * T + 10, 50, -1, -1);

    send(32'h13572468, 1'b0);
    repeat (100) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async reset mid-frame", {60'd0, busy, done, ir_envelope, ir_output}, 64'd0);
    #1 rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("idle after abort", {60'd0, busy, done, ir_envelope, ir_output}, 64'd0);

    send(32'hCAFEF00D, 1'b0);
    capture("f7", -1, 0, -1, -1);
    check("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
